// File: rtl/weight_pkg.sv
// Shared types and sizing for the weight fetch/stage path.
package weight_pkg;

    localparam int unsigned ROWS           = 4;
    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned ADDR_W_DEF     = 10;
    localparam int unsigned ROW_W          = 2;
    localparam int unsigned TILE_W         = 8;
    localparam int unsigned DATA_W         = 32;
    localparam int unsigned FEED_W         = 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_LAST,
        S_LOAD,
        S_FEED,
        S_DONE
    } wf_state_e;

endpackage

// File: rtl/wf_addr_gen.sv
// Tile/row counters and the wrapping weight-memory address; addr is registered
// from the next counter values so it lines up with the current read row.
module wf_addr_gen
    import weight_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              row_step,
    input  logic              tile_step,
    input  logic [ADDR_W-1:0] base_addr,
    output logic [TILE_W-1:0] tile,
    output logic [ROW_W-1:0]  row,
    output logic [ADDR_W-1:0] addr
);

    logic [ADDR_W-1:0] base_q, base_d;
    logic [TILE_W-1:0] tile_q, tile_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [ADDR_W-1:0] addr_q, addr_d;

    always_comb begin
        base_d = base_q;
        tile_d = tile_q;
        row_d  = row_q;
        if (load) begin
            base_d = base_addr;
            tile_d = '0;
            row_d  = '0;
        end else if (tile_step) begin
            tile_d = tile_q + TILE_W'(1);
            row_d  = '0;
        end else if (row_step) begin
            row_d = row_q + ROW_W'(1);
        end
        // Natural ADDR_W-bit overflow gives the required wrap.
        addr_d = base_d + (ADDR_W'(tile_d) << $clog2(ROWS)) + ADDR_W'(row_d);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            base_q <= '0;
            tile_q <= '0;
            row_q  <= '0;
            addr_q <= '0;
        end else begin
            base_q <= base_d;
            tile_q <= tile_d;
            row_q  <= row_d;
            addr_q <= addr_d;
        end
    end

    assign tile = tile_q;
    assign row  = row_q;
    assign addr = addr_q;

endmodule

// File: rtl/weight_fetch.sv
// Reads 4x4-byte weight tiles row by row, stages them in dinA..dinD and
// drives the weight feeder's load/shift strobes.
module weight_fetch
    import weight_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [7:0]        num_tiles,
    input  logic              hold,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_rdata,
    output logic [31:0]       dinA,
    output logic [31:0]       dinB,
    output logic [31:0]       dinC,
    output logic [31:0]       dinD,
    output logic              en_in,
    output logic              en_out,
    output logic              busy,
    output logic              done
);

    wf_state_e         state_q, state_d;
    logic [TILE_W-1:0] num_q;
    logic [FEED_W-1:0] feed_cnt_q;
    logic [TILE_W-1:0] tile;
    logic [ROW_W-1:0]  row;
    logic              load, row_step, tile_step, feed_fire, last_tile;
    logic              mem_en_q, en_in_q, busy_q, done_q;
    logic              cap_vld_q;
    logic [ROW_W-1:0]  cap_row_q;
    logic [DATA_W-1:0] din_a_q, din_b_q, din_c_q, din_d_q;

    wf_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .row_step  (row_step),
        .tile_step (tile_step),
        .base_addr (base_addr),
        .tile      (tile),
        .row       (row),
        .addr      (mem_addr)
    );

    assign last_tile = (tile == num_q - TILE_W'(1));

    always_comb begin
        state_d   = state_q;
        load      = 1'b0;
        row_step  = 1'b0;
        tile_step = 1'b0;
        feed_fire = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (num_tiles != 8'd0) begin
                        state_d = S_RD;
                        load    = 1'b1;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_RD: begin
                row_step = 1'b1;
                if (row == ROW_W'(ROWS - 1)) state_d = S_LAST;
            end
            S_LAST: state_d = S_LOAD;
            S_LOAD: state_d = S_FEED;
            S_FEED: begin
                if (!hold) begin
                    feed_fire = 1'b1;
                    if (feed_cnt_q == FEED_W'(BYTES_PER_WORD - 1)) begin
                        if (last_tile) begin
                            state_d = S_DONE;
                        end else begin
                            state_d   = S_RD;
                            tile_step = 1'b1;
                        end
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            mem_en_q <= 1'b0;
            en_in_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mem_en_q <= (state_d == S_RD);
            en_in_q  <= (state_d == S_LOAD);
            busy_q   <= (state_d != S_IDLE);
            done_q   <= (state_d == S_DONE);
        end
    end

    // Read data returns one cycle after the strobe; remember which row it belongs to.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            num_q      <= '0;
            feed_cnt_q <= '0;
            cap_vld_q  <= 1'b0;
            cap_row_q  <= '0;
            din_a_q    <= '0;
            din_b_q    <= '0;
            din_c_q    <= '0;
            din_d_q    <= '0;
        end else begin
            if (load) num_q <= num_tiles;
            if (feed_fire) feed_cnt_q <= feed_cnt_q + FEED_W'(1);
            cap_vld_q <= mem_en_q;
            cap_row_q <= row;
            if (cap_vld_q) begin
                case (cap_row_q)
                    2'd0:    din_a_q <= mem_rdata;
                    2'd1:    din_b_q <= mem_rdata;
                    2'd2:    din_c_q <= mem_rdata;
                    default: din_d_q <= mem_rdata;
                endcase
            end
        end
    end

    assign mem_en = mem_en_q;
    assign en_in  = en_in_q;
    assign en_out = feed_fire;
    assign busy   = busy_q;
    assign done   = done_q;
    assign dinA   = din_a_q;
    assign dinB   = din_b_q;
    assign dinC   = din_c_q;
    assign dinD   = din_d_q;

endmodule

// File: tb/tb_weight_fetch.sv
// Directed bench for weight_fetch: per-cycle trace of one run against hand-derived cycle masks.
module tb_weight_fetch;

    logic        clk;
    logic        rst;
    logic        start;
    logic [9:0]  base_addr;
    logic [7:0]  num_tiles;
    logic        hold;
    logic        mem_en;
    logic [9:0]  mem_addr;
    logic [31:0] mem_rdata;
    logic [31:0] dinA, dinB, dinC, dinD;
    logic        en_in, en_out, busy, done;

    weight_fetch #(.ADDR_W(10)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .num_tiles (num_tiles),
        .hold      (hold),
        .mem_en    (mem_en),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .dinA      (dinA),
        .dinB      (dinB),
        .dinC      (dinC),
        .dinD      (dinD),
        .en_in     (en_in),
        .en_out    (en_out),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] mem [1024];
    always @(posedge clk) if (mem_en) mem_rdata <= mem[mem_addr];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Trace of the most recent run; bit c of a mask = event seen in cycle c after start.
    logic [63:0] en_m, in_m, out_m, done_m;
    logic [9:0]  addrs [$];
    logic [31:0] ld [4];
    logic        overlap;
    logic        rst_val;

    task automatic run(input logic [9:0] base, input logic [7:0] tiles,
                       input logic [63:0] hold_m, input logic [63:0] start_m,
                       input logic [63:0] rst_m, input int ncyc);
        en_m = '0; in_m = '0; out_m = '0; done_m = '0;
        addrs.delete();
        for (int k = 0; k < 4; k++) ld[k] = '0;
        overlap = 1'b0;
        rst_val = 1'b1;
        start = 1'b1; base_addr = base; num_tiles = tiles;
        @(posedge clk); #1;
        start = 1'b0; base_addr = 10'h155; num_tiles = 8'd7;
        for (int c = 1; c <= ncyc; c++) begin
            hold  = hold_m[c];
            start = start_m[c];
            if (start_m[c]) begin
                base_addr = 10'h200;
                num_tiles = 8'd0;
            end
            rst = rst_m[c];
            #1;
            if (mem_en) begin
                en_m[c] = 1'b1;
                addrs.push_back(mem_addr);
            end
            if (en_in) begin
                in_m[c] = 1'b1;
                ld[0] = dinA; ld[1] = dinB; ld[2] = dinC; ld[3] = dinD;
            end
            if (en_out) out_m[c] = 1'b1;
            if (done) done_m[c] = 1'b1;
            if (en_in && en_out) overlap = 1'b1;
            if (rst_m[c])
                rst_val = |{mem_en, en_in, en_out, busy, done, mem_addr, dinA, dinB, dinC, dinD};
            @(posedge clk); #1;
        end
        start = 1'b0; hold = 1'b0; rst = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'hC0DE_0000 | 32'(i);
        mem[10'h010] = 32'h1122_3344;
        mem[10'h011] = 32'h5566_7788;
        mem[10'h012] = 32'h99AA_BBCC;
        mem[10'h013] = 32'hDDEE_FF00;
        rst = 1'b1; start = 1'b0; base_addr = '0; num_tiles = '0; hold = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_ctrl", 64'({mem_en, en_in, en_out, busy, done}), 64'd0);
        check_eq("rst_addr", 64'(mem_addr), 64'd0);
        check_eq("rst_din", 64'(dinA | dinB | dinC | dinD), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Single tile at 0x010.
        run(10'h010, 8'd1, 64'd0, 64'd0, 64'd0, 15);
        check_eq("t1_mem_en", en_m, 64'h1E);
        check_eq("t1_addr0", 64'(addrs[0]), 64'h10);
        check_eq("t1_addr3", 64'(addrs[3]), 64'h13);
        check_eq("t1_en_in", in_m, 64'h40);
        check_eq("t1_dinA", 64'(ld[0]), 64'h1122_3344);
        check_eq("t1_dinB", 64'(ld[1]), 64'h5566_7788);
        check_eq("t1_dinC", 64'(ld[2]), 64'h99AA_BBCC);
        check_eq("t1_dinD", 64'(ld[3]), 64'hDDEE_FF00);
        check_eq("t1_en_out", out_m, 64'h780);
        check_eq("t1_done", done_m, 64'h800);
        check_eq("t1_overlap", 64'(overlap), 64'd0);
        check_eq("t1_din_hold", 64'(dinA), 64'h1122_3344);

        // Three tiles from 0.
        run(10'h000, 8'd3, 64'd0, 64'd0, 64'd0, 35);
        check_eq("t2_nrd", 64'(addrs.size()), 64'd12);
        for (int i = 0; i < 12; i++)
            check_eq($sformatf("t2_addr%0d", i), 64'(addrs[i]), 64'(i));
        check_eq("t2_n_in", 64'($countones(in_m)), 64'd3);
        check_eq("t2_n_out", 64'($countones(out_m)), 64'd12);
        check_eq("t2_done", done_m, 64'h1 << 31);
        check_eq("t2_last_dinA", 64'(ld[0]), 64'hC0DE_0008);
        check_eq("t2_last_dinD", 64'(ld[3]), 64'hC0DE_000B);
        check_eq("t2_overlap", 64'(overlap), 64'd0);

        // Address wrap.
        run(10'h3FE, 8'd1, 64'd0, 64'd0, 64'd0, 13);
        check_eq("t3_addr0", 64'(addrs[0]), 64'h3FE);
        check_eq("t3_addr1", 64'(addrs[1]), 64'h3FF);
        check_eq("t3_addr2", 64'(addrs[2]), 64'h000);
        check_eq("t3_addr3", 64'(addrs[3]), 64'h001);
        check_eq("t3_dinC", 64'(ld[2]), 64'hC0DE_0000);

        // Hold in FEED cycles 8-9, plus a stray hold in RD that must be ignored.
        run(10'h010, 8'd1, 64'h308, 64'd0, 64'd0, 16);
        check_eq("t4_mem_en", en_m, 64'h1E);
        check_eq("t4_en_out", out_m, 64'h1C80);
        check_eq("t4_done", done_m, 64'h2000);

        // Zero tiles.
        run(10'h010, 8'd0, 64'd0, 64'd0, 64'd0, 4);
        check_eq("t5_mem_en", en_m, 64'd0);
        check_eq("t5_done", done_m, 64'h2);

        // Start while busy (RD and DONE) with new base/tiles is ignored.
        run(10'h010, 8'd1, 64'd0, 64'h808, 64'd0, 15);
        check_eq("t6_addr0", 64'(addrs[0]), 64'h10);
        check_eq("t6_nrd", 64'(addrs.size()), 64'd4);
        check_eq("t6_done", done_m, 64'h800);

        // Reset in FEED abandons the run.
        run(10'h010, 8'd1, 64'd0, 64'd0, 64'h100, 15);
        check_eq("t7_rst_outs", 64'(rst_val), 64'd0);
        check_eq("t7_done", done_m, 64'd0);
        check_eq("t7_no_more_rd", en_m, 64'h1E);

        // Normal run after reset.
        run(10'h010, 8'd1, 64'd0, 64'd0, 64'd0, 15);
        check_eq("t8_done", done_m, 64'h800);
        check_eq("t8_dinB", 64'(ld[1]), 64'h5566_7788);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
